// File: rtl/rf_write_responder.sv
// Responder end of the 4-phase req/ack register-file write handshake, with two combinational read ports.
// Optional build macro RF_R0_ZERO_EN hardwires register 0 to zero.
module rf_write_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ack,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_r1,
  input  logic [ADDR_W-1:0] addr_r2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              busy,
  output logic [15:0]       wr_count
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [15:0]              wr_count_q, wr_count_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic                     req_s;
  logic                     wr_en;
  logic                     wr_ok;

  // Only the last synchroniser flop is safe to look at.
  assign req_s = sync_q[SYNC_STAGES-1];

`ifdef RF_R0_ZERO_EN
  assign wr_ok = we & (addr_w != '0);
`else
  assign wr_ok = we;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], req};
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: if (req_s) begin
        state_d = ACK;
        ack_d   = 1'b1;
        wr_en   = wr_ok;
      end
      ACK: if (!req_s) begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
    wr_count_d = wr_en ? wr_count_q + 16'd1 : wr_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Bundled data is stable across the whole req-to-ack window, so it is sampled directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[addr_w] <= data_in;
    end
  end

`ifdef RF_R0_ZERO_EN
  assign data_out1 = (addr_r1 == '0) ? '0 : mem_q[addr_r1];
  assign data_out2 = (addr_r2 == '0) ? '0 : mem_q[addr_r2];
`else
  assign data_out1 = mem_q[addr_r1];
  assign data_out2 = mem_q[addr_r2];
`endif

  assign ack      = ack_q;
  assign busy     = (state_q != IDLE);
  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_rf_write_responder.sv
// Scoreboard bench for rf_write_responder: handshake latency, commits, read ports, reset, counter wrap, R0.
module tb_rf_write_responder;
  localparam int SS = 2;
`ifdef RF_R0_ZERO_EN
  localparam bit R0EN = 1'b1;
`else
  localparam bit R0EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic        we = 1'b0;
  logic [3:0]  addr_w = '0;
  logic [15:0] data_in = '0;
  logic [3:0]  addr_r1 = '0;
  logic [3:0]  addr_r2 = '0;
  logic [15:0] data_out1, data_out2;
  logic        busy;
  logic [15:0] wr_count;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] mm [16];
  logic [15:0] cnt;
  int          checks = 0;
  int          errors = 0;

  rf_write_responder #(.DATA_W(16), .ADDR_W(4), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .we(we), .addr_w(addr_w),
    .data_in(data_in), .addr_r1(addr_r1), .addr_r2(addr_r2), .data_out1(data_out1),
    .data_out2(data_out2), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_model(input logic [3:0] a);
    if (R0EN && a == 4'd0) return 16'h0;
    return mm[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mm[i] = 16'h0;
    cnt = 16'h0;
  endtask

  task automatic push_exp(input logic w, input logic [3:0] a, input logic [15:0] d);
    sb_t e;
    e.we = w && !(R0EN && a == 4'd0);
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pop_commit();
    sb_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: ack seen with no expected transaction");
    end else begin
      e = sb.pop_front();
      if (e.we) begin mm[e.addr] = e.data; cnt = cnt + 16'd1; end
    end
  endtask

  // Full handshake: req rise, ack rise after SS+1 edges, hold, req fall, ack fall after SS+1 edges.
  task automatic handshake(input string nm, input logic w, input logic [3:0] a,
                           input logic [15:0] d, input int hold);
    int n;
    logic [15:0] old;
    we = w; addr_w = a; data_in = d; addr_r1 = a;
    old = rd_model(a);
    push_exp(w, a, d);
    @(negedge clk); req = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk); #1; n++;
      if (ack || n >= 20) break;
      checks++;
      if (data_out1 !== old) begin
        errors++; $display("FAIL %s_nobypass: data_out1=%h required %h", nm, data_out1, old);
      end
    end
    checks++;
    if (!ack || n != SS + 1) begin
      errors++; $display("FAIL %s_ack_rise: ack=%b after %0d edges, required 1 after %0d", nm, ack, n, SS + 1);
    end
    if (ack) pop_commit();
    checks++;
    if (data_out1 !== rd_model(a)) begin
      errors++; $display("FAIL %s_rd1: data_out1=%h required %h", nm, data_out1, rd_model(a));
    end
    checks++;
    if (data_out2 !== rd_model(addr_r2)) begin
      errors++; $display("FAIL %s_rd2: data_out2=%h required %h", nm, data_out2, rd_model(addr_r2));
    end
    checks++;
    if (wr_count !== cnt || busy !== 1'b1) begin
      errors++; $display("FAIL %s_count: wr_count=%h busy=%b required %h 1", nm, wr_count, busy, cnt);
    end
    repeat (hold) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b1 || wr_count !== cnt) begin
      errors++; $display("FAIL %s_hold: ack=%b wr_count=%h required 1 %h", nm, ack, wr_count, cnt);
    end
    @(negedge clk); req = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clk); #1; n++;
      if (!ack || n >= 20) break;
    end
    checks++;
    if (ack || n != SS + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_ack_fall: ack=%b busy=%b after %0d edges, required 0 0 after %0d", nm, ack, busy, n, SS + 1);
    end
    checks++;
    if (wr_count !== cnt || data_out1 !== rd_model(a)) begin
      errors++; $display("FAIL %s_after: wr_count=%h data_out1=%h required %h %h", nm, wr_count, data_out1, cnt, rd_model(a));
    end
  endtask

  task automatic test_reset();
    model_clear();
    addr_r1 = 4'd3; addr_r2 = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || wr_count !== 16'h0 || data_out1 !== 16'h0 || data_out2 !== 16'h0) begin
      errors++; $display("FAIL reset_state: ack=%b busy=%b wr_count=%h rd=%h/%h required 0 0 0000 0000/0000", ack, busy, wr_count, data_out1, data_out2);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    addr_r2 = 4'd3;
    handshake("write", 1'b1, 4'd3, 16'hBEEF, 0);
    handshake("write2", 1'b1, 4'd10, 16'hA5C3, 2);
  endtask

  task automatic test_we0();
    addr_r2 = 4'd3;
    handshake("we0", 1'b0, 4'd3, 16'h1234, 1);
  endtask

  task automatic test_long_req();
    addr_r2 = 4'd10;
    handshake("long", 1'b1, 4'd6, 16'h0F0F, 20);
  endtask

  task automatic test_r0();
    addr_r2 = 4'd0;
    handshake("r0", 1'b1, 4'd0, 16'h5555, 0);
  endtask

  task automatic test_reset_mid();
    int n;
    we = 1'b1; addr_w = 4'd7; data_in = 16'h7777; addr_r1 = 4'd3; addr_r2 = 4'd10;
    @(negedge clk); req = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk); #1; n++;
      if (ack || n >= 20) break;
    end
    checks++;
    if (!ack) begin errors++; $display("FAIL rstmid_ack: ack=%b required 1", ack); end
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || wr_count !== 16'h0 || data_out1 !== 16'h0 || data_out2 !== 16'h0) begin
      errors++; $display("FAIL rstmid_clear: ack=%b busy=%b wr_count=%h rd=%h/%h required 0 0 0000 0000/0000", ack, busy, wr_count, data_out1, data_out2);
    end
    // req still high: after release it must be taken as a fresh request.
    push_exp(1'b1, 4'd7, 16'h7777);
    addr_r1 = 4'd7;
    @(negedge clk); reset = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk); #1; n++;
      if (ack || n >= 20) break;
    end
    checks++;
    if (!ack || n != SS + 1) begin
      errors++; $display("FAIL rstmid_rereq: ack=%b after %0d edges, required 1 after %0d", ack, n, SS + 1);
    end
    if (ack) pop_commit();
    checks++;
    if (wr_count !== cnt || data_out1 !== rd_model(4'd7)) begin
      errors++; $display("FAIL rstmid_commit: wr_count=%h data_out1=%h required %h %h", wr_count, data_out1, cnt, rd_model(4'd7));
    end
    @(negedge clk); req = 1'b0;
    repeat (SS + 2) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: ack=%b busy=%b required 0 0", ack, busy);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.wr_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.wr_count_q;
    cnt = 16'hFFFF;
    #1;
    checks++;
    if (wr_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: wr_count=%h required ffff", wr_count);
    end
    addr_r2 = 4'd7;
    handshake("wrap", 1'b1, 4'd12, 16'hC0DE, 0);
    checks++;
    if (wr_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: wr_count=%h required 0000", wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_we0();
    test_long_req();
    test_r0();
    test_reset_mid();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
